// File: rtl/mem_pkg.sv
// Shared types for the memory responder: request entry layout and FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_pkg;

    localparam int ADDR_W      = 64;
    localparam int LINE_BITS   = 512;
    localparam int OFFSET_BITS = 6;

    // One queued request: line-aligned address, write flag, write-back data.
    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic                 we;
        logic [LINE_BITS-1:0] data;
    } mem_req_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } mem_resp_state_t;

    // Clear the byte-offset bits so every stored/returned address names a whole line.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/req_fifo.sv
// Generic synchronous FIFO holding WIDTH-bit entries, DEPTH (power of two) deep.
// Latency: push visible at head one cycle later; head is read combinationally.
// Backpressure: pushes while full and pops while empty are ignored; count/full/empty are registered.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/push_dat_i write side;
//        pop_i/pop_dat_o read side; count_o, full_o, empty_o occupancy status.
module req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign push_ok   = push_i && !full_o;
    assign pop_ok    = pop_i && !empty_o;
    assign pop_dat_o = store_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (push_ok) store_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/mem_responder.sv
// Line-granular backing store standing in for DRAM below the last-level cache.
// Latency: read accepted into an idle unit returns data LATENCY+1 edges later; writes commit at the same point.
// Backpressure: req_ready_out drops when the Q_DEPTH-entry queue is full; a read response holds until resp_ready_in.
// Ports: clk_in/rst_N_in clock and async active-low reset; req_* request channel (addr, we, line data);
//        resp_* read-response channel (line-aligned addr, line data); busy_out = work queued or in flight.
module mem_responder
    import mem_pkg::*;
#(
    parameter int W           = ADDR_W,
    parameter int LINE_BITS   = mem_pkg::LINE_BITS,
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 8,
    parameter int Q_DEPTH     = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_N_in,
    input  logic                 req_valid_in,
    output logic                 req_ready_out,
    input  logic [W-1:0]         req_addr_in,
    input  logic                 req_we_in,
    input  logic [LINE_BITS-1:0] req_value_in,
    output logic                 resp_valid_out,
    input  logic                 resp_ready_in,
    output logic [W-1:0]         resp_addr_out,
    output logic [LINE_BITS-1:0] resp_value_out,
    output logic                 busy_out
);
    localparam int IDX_W  = $clog2(DEPTH_LINES);
    localparam int CNT_W  = $clog2(LATENCY + 1);
    localparam int QW     = $bits(mem_req_t);
    localparam int QCNT_W = $clog2(Q_DEPTH + 1);

    mem_resp_state_t      state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    mem_req_t             cur_q, cur_d;
    logic [W-1:0]         resp_addr_q, resp_addr_d;
    logic [LINE_BITS-1:0] resp_value_q, resp_value_d;
    logic [LINE_BITS-1:0] mem_q [DEPTH_LINES];

    mem_req_t             push_req, head_req;
    logic [QW-1:0]        head_dat;
    logic [QCNT_W-1:0]    fifo_count;
    logic                 fifo_full, fifo_empty, push, pop;
    logic [IDX_W-1:0]     cur_idx;
    logic                 last_cycle, commit_wr;

    always_comb begin
        push_req      = '0;
        push_req.addr = line_align(req_addr_in);
        push_req.we   = req_we_in;
        push_req.data = req_value_in;
    end

    assign req_ready_out = (fifo_count < QCNT_W'(Q_DEPTH));
    assign push          = req_valid_in && !fifo_full;
    assign head_req      = mem_req_t'(head_dat);

    req_fifo #(
        .WIDTH (QW),
        .DEPTH (Q_DEPTH),
        .CNT_W (QCNT_W)
    ) u_req_fifo (
        .clk_i      (clk_in),
        .rst_ni     (rst_N_in),
        .push_i     (push),
        .push_dat_i (push_req),
        .pop_i      (pop),
        .pop_dat_o  (head_dat),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Higher address bits alias onto the store modulo DEPTH_LINES.
    assign cur_idx    = cur_q.addr[OFFSET_BITS +: IDX_W];
    assign last_cycle = (state_q == ST_WAIT) && (cnt_q == CNT_W'(1));
    assign commit_wr  = last_cycle && cur_q.we;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_d        = cur_q;
        resp_addr_d  = resp_addr_q;
        resp_value_d = resp_value_q;
        pop          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) pop = 1'b1;
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    if (cur_q.we) begin
                        // Write commits this edge; the next request may start immediately.
                        if (!fifo_empty) pop = 1'b1;
                        else             state_d = ST_IDLE;
                    end else begin
                        resp_addr_d  = cur_q.addr;
                        resp_value_d = mem_q[cur_idx];
                        state_d      = ST_RESPOND;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESPOND: begin
                if (resp_ready_in) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Every pop starts a fresh access window for the new head.
        if (pop) begin
            cur_d   = head_req;
            cnt_d   = CNT_W'(LATENCY);
            state_d = ST_WAIT;
        end
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cur_q        <= '0;
            resp_addr_q  <= '0;
            resp_value_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_q        <= cur_d;
            resp_addr_q  <= resp_addr_d;
            resp_value_q <= resp_value_d;
        end
    end

    // Backing store is not reset; a reset while a write is in WAIT drops it uncommitted.
    always_ff @(posedge clk_in) begin
        if (commit_wr) mem_q[cur_idx] <= cur_q.data;
    end

    assign resp_valid_out = (state_q == ST_RESPOND);
    assign resp_addr_out  = resp_addr_q;
    assign resp_value_out = resp_value_q;
    assign busy_out       = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
    localparam int LAT = 8;

    logic         clk_in = 1'b0;
    logic         rst_N_in = 1'b1;
    logic         req_valid_in;
    logic         req_ready_out;
    logic [63:0]  req_addr_in;
    logic         req_we_in;
    logic [511:0] req_value_in;
    logic         resp_valid_out;
    logic         resp_ready_in;
    logic [63:0]  resp_addr_out;
    logic [511:0] resp_value_out;
    logic         busy_out;

    mem_responder #(
        .W(64), .LINE_BITS(512), .DEPTH_LINES(1024), .LATENCY(LAT), .Q_DEPTH(4)
    ) dut (
        .clk_in         (clk_in),
        .rst_N_in       (rst_N_in),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .req_addr_in    (req_addr_in),
        .req_we_in      (req_we_in),
        .req_value_in   (req_value_in),
        .resp_valid_out (resp_valid_out),
        .resp_ready_in  (resp_ready_in),
        .resp_addr_out  (resp_addr_out),
        .resp_value_out (resp_value_out),
        .busy_out       (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int resp_count = 0;

    // Reference model: line contents plus the ordered list of accepted requests.
    typedef struct {
        logic [63:0]  addr;
        bit           we;
        logic [511:0] data;
    } req_t;
    logic [511:0] mem_m [1024];
    req_t         pend[$];

    function automatic int idx(input logic [63:0] a);
        return int'(a[15:6]);
    endfunction

    function automatic logic [63:0] align(input logic [63:0] a);
        logic [63:0] r;
        r = a;
        r[5:0] = 6'd0;
        return r;
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare process: every cycle, outputs are checked against the model.
    logic         prev_hold = 1'b0;
    logic [63:0]  prev_addr;
    logic [511:0] prev_val;
    always @(negedge clk_in) begin
        if (!rst_N_in) begin
            pend.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 512'(resp_valid_out), 512'(1));
                check("hold_addr", 512'(resp_addr_out), 512'(prev_addr));
                check("hold_value", resp_value_out, prev_val);
            end
            // Unit idle: everything accepted so far has completed.
            if (!busy_out) begin
                while (pend.size() > 0) begin
                    if (pend[0].we) begin
                        mem_m[idx(pend[0].addr)] = pend[0].data;
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL lost_read: addr %0h never answered", pend[0].addr);
                    end
                    void'(pend.pop_front());
                end
            end
            if (resp_valid_out) begin
                // A read response means every earlier write has landed.
                while (pend.size() > 0 && pend[0].we) begin
                    mem_m[idx(pend[0].addr)] = pend[0].data;
                    void'(pend.pop_front());
                end
                if (pend.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_resp: addr %0h with no read outstanding", resp_addr_out);
                end else begin
                    check("resp_addr", 512'(resp_addr_out), 512'(align(pend[0].addr)));
                    check("resp_value", resp_value_out, mem_m[idx(pend[0].addr)]);
                    if (resp_ready_in) begin
                        void'(pend.pop_front());
                        resp_count++;
                    end
                end
            end
            prev_hold = resp_valid_out && !resp_ready_in;
            prev_addr = resp_addr_out;
            prev_val  = resp_value_out;
            if (req_valid_in && req_ready_out)
                pend.push_back('{req_addr_in, req_we_in, req_value_in});
        end
    end

    // Called between a rising edge and the next falling edge.
    task automatic try_send(input logic [63:0] a, input bit we, input logic [511:0] d,
                            input int max_cyc, output bit ok);
        ok = 1'b0;
        req_addr_in  = a;
        req_we_in    = we;
        req_value_in = d;
        req_valid_in = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk_in);
            if (req_ready_out) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk_in);
        #1;
        req_valid_in = 1'b0;
    endtask

    task automatic send(input logic [63:0] a, input bit we, input logic [511:0] d);
        bit ok;
        try_send(a, we, d, 500, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: addr %0h not accepted, required acceptance", a);
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!resp_valid_out && cyc < 100) begin
            @(posedge clk_in);
            #1;
            cyc++;
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_in);
            if (!busy_out) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout: busy_out still 1, required 0");
        end
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [511:0] a5, pat, pat2, v0, d;
        logic [63:0]  a, a0;
        int           c, acc, base;
        bit           ok;
        bit           done;

        a5   = {64{8'hA5}};
        pat  = {8{64'h1234_5678_9ABC_DEF0}};
        pat2 = {16{32'hC0DE_0001}};
        for (int i = 0; i < 1024; i++) mem_m[i] = '0;
        req_valid_in  = 1'b0;
        req_addr_in   = '0;
        req_we_in     = 1'b0;
        req_value_in  = '0;
        resp_ready_in = 1'b0;

        #1 rst_N_in = 1'b0;
        #11;
        check("rst_ready", 512'(req_ready_out), 512'(1));
        check("rst_valid", 512'(resp_valid_out), 512'(0));
        check("rst_addr", 512'(resp_addr_out), 512'(0));
        check("rst_value", resp_value_out, 512'(0));
        check("rst_busy", 512'(busy_out), 512'(0));
        @(posedge clk_in);
        #1 rst_N_in = 1'b1;

        // Preload lines 0..15 with zero, line 5 with A5 pattern.
        resp_ready_in = 1'b1;
        for (int l = 0; l < 16; l++) send(64'(l * 64), 1'b1, (l == 5) ? a5 : 512'd0);
        wait_idle();

        // Single read from idle.
        send(64'h140, 1'b0, '0);
        wait_valid(c);
        check("read_latency", 512'(c), 512'(LAT + 1));
        check("read_addr", 512'(resp_addr_out), 512'h140);
        check("read_data", resp_value_out, a5);
        wait_idle();

        // Write then read back-to-back, unaligned write address.
        send(64'h1C7, 1'b1, pat);
        send(64'h1C0, 1'b0, '0);
        wait_valid(c);
        check("raw_addr", 512'(resp_addr_out), 512'h1C0);
        check("raw_data", resp_value_out, pat);
        wait_idle();

        // Queue full with responses stalled.
        resp_ready_in = 1'b0;
        base = resp_count;
        acc  = 0;
        for (int k = 0; k < 6; k++) begin
            try_send(64'(k * 64), 1'b0, '0, 20, ok);
            if (ok) acc++;
        end
        check("full_accepted", 512'(acc), 512'(5));
        check("full_ready", 512'(req_ready_out), 512'(0));
        resp_ready_in = 1'b1;
        wait_idle();
        check("full_drained", 512'(resp_count - base), 512'(5));

        // Aliasing: line 1024 maps onto line 0.
        send(64'h10000, 1'b1, pat2);
        send(64'h0, 1'b0, '0);
        wait_valid(c);
        check("alias_addr", 512'(resp_addr_out), 512'h0);
        check("alias_data", resp_value_out, pat2);
        wait_idle();

        // Response stall: outputs stable, then exactly one transfer.
        resp_ready_in = 1'b0;
        send(64'h140, 1'b0, '0);
        wait_valid(c);
        a0 = resp_addr_out;
        v0 = resp_value_out;
        check("stall_data", v0, a5);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk_in);
            #1;
            check("stall_valid", 512'(resp_valid_out), 512'(1));
            check("stall_addr", 512'(resp_addr_out), 512'(a0));
            check("stall_value", resp_value_out, v0);
        end
        base = resp_count;
        resp_ready_in = 1'b1;
        @(posedge clk_in);
        #1 resp_ready_in = 1'b0;
        @(posedge clk_in);
        #1;
        check("stall_release_valid", 512'(resp_valid_out), 512'(0));
        check("stall_release_count", 512'(resp_count - base), 512'(1));
        resp_ready_in = 1'b1;
        wait_idle();

        // Reset during WAIT of a write: write must be dropped.
        base = resp_count;
        send(64'hC0, 1'b1, {512{1'b1}});
        repeat (3) @(posedge clk_in);
        #1 rst_N_in = 1'b0;
        #1;
        check("mid_rst_ready", 512'(req_ready_out), 512'(1));
        check("mid_rst_valid", 512'(resp_valid_out), 512'(0));
        check("mid_rst_busy", 512'(busy_out), 512'(0));
        check("mid_rst_value", resp_value_out, 512'(0));
        repeat (2) @(posedge clk_in);
        #1 rst_N_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        check("post_rst_busy", 512'(busy_out), 512'(0));
        check("post_rst_no_resp", 512'(resp_count - base), 512'(0));
        send(64'hC0, 1'b0, '0);
        wait_valid(c);
        check("dropped_write_data", resp_value_out, 512'(0));
        wait_idle();

        // Randomized traffic with random response backpressure.
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    a = {$urandom, $urandom};
                    a[15:10] = 6'd0;
                    for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
                    send(a, 1'($urandom_range(0, 1)), d);
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk_in);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk_in);
                    #1 resp_ready_in = ($urandom_range(0, 3) != 0);
                end
            end
        join
        resp_ready_in = 1'b1;
        wait_idle();
        @(negedge clk_in);
        check("final_pending", 512'(pend.size()), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
